kb_calc_ctrl: RTL and testbench

KB_CALC_CTRL -- requirements
Module: kb_calc_ctrl

---
 rtl/kb_calc_if.sv | 15 +
 rtl/kb_calc_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_kb_calc_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/kb_calc_if.sv
// Key-strobe bundle between the PS/2 front end and the calculator.
interface kb_calc_if;
  logic [8:0] key_code;
  logic       key_valid;

  modport master (
    output key_code,
    output key_valid
  );

  modport slave (
    input key_code,
    input key_valid
  );
endinterface

// File: rtl/kb_calc_ctrl.sv
// Keyboard calculator controller: operand entry, arithmetic, BCD display.
// Define KBCALC_MUL_EN to decode keypad '*' as multiply.
module kb_calc_ctrl #(
  parameter int  DIGITS = 2,
  localparam int DISP_N = 2 * DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  kb_calc_if.slave            kb,
  output logic [4*DISP_N-1:0] disp,
  output logic                neg,
  output logic                busy,
  output logic [2:0]          state
);

  localparam int W  = $clog2(10 ** DISP_N);
  localparam int CW = $clog2(W + 1);
  localparam int DB = 4 * DISP_N;

  localparam logic [W-1:0]  TEN   = W'(10);
  localparam logic [2:0]    DMAX  = 3'(DIGITS);
  localparam logic [CW-1:0] CLAST = CW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OPA    = 3'd1,
    S_OPB    = 3'd2,
    S_CONV   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [2:0]    na_q, na_d;
  logic [2:0]    nb_q, nb_d;
  logic [CW-1:0] cc_q, cc_d;
  logic [DB-1:0] bcd_q, bcd_d;
  logic [DB-1:0] disp_q, disp_d;
  logic          sign_q, sign_d;
  logic          neg_q, neg_d;
  logic          busy_q, busy_d;

  logic          is_dig, is_op, is_ent, is_esc;
  logic [3:0]    dig;
  op_t           op_k;
  logic [W-1:0]  dig_w;
  logic [W-1:0]  diff, res_v;
  logic          lt_v;
  logic [DB-1:0] bcd_adj, bcd_step;
  logic [DB-1:0] disp_dig;

  always_comb begin
    is_dig = 1'b0;
    is_op  = 1'b0;
    is_ent = 1'b0;
    is_esc = 1'b0;
    dig    = 4'd0;
    op_k   = OP_ADD;
    if (kb.key_valid && !kb.key_code[8]) begin
      case (kb.key_code[7:0])
        8'h45: begin is_dig = 1'b1; dig = 4'd0; end
        8'h16: begin is_dig = 1'b1; dig = 4'd1; end
        8'h1E: begin is_dig = 1'b1; dig = 4'd2; end
        8'h26: begin is_dig = 1'b1; dig = 4'd3; end
        8'h25: begin is_dig = 1'b1; dig = 4'd4; end
        8'h2E: begin is_dig = 1'b1; dig = 4'd5; end
        8'h36: begin is_dig = 1'b1; dig = 4'd6; end
        8'h3D: begin is_dig = 1'b1; dig = 4'd7; end
        8'h3E: begin is_dig = 1'b1; dig = 4'd8; end
        8'h46: begin is_dig = 1'b1; dig = 4'd9; end
        8'h79: begin is_op = 1'b1; op_k = OP_ADD; end
        8'h7B: begin is_op = 1'b1; op_k = OP_SUB; end
`ifdef KBCALC_MUL_EN
        8'h7C: begin is_op = 1'b1; op_k = OP_MUL; end
`endif
        8'h5A: is_ent = 1'b1;
        8'h76: is_esc = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    dig_w    = {{(W-4){1'b0}}, dig};
    disp_dig = {{(DB-4){1'b0}}, dig};
    lt_v     = a_q < b_q;
    diff     = lt_v ? (b_q - a_q) : (a_q - b_q);
    case (op_q)
      OP_SUB:  res_v = diff;
`ifdef KBCALC_MUL_EN
      OP_MUL:  res_v = a_q * b_q;
`endif
      default: res_v = a_q + b_q;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DISP_N; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[DB-2:0], sh_q[W-1]};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    sh_d    = sh_q;
    na_d    = na_q;
    nb_d    = nb_q;
    cc_d    = cc_q;
    bcd_d   = bcd_q;
    disp_d  = disp_q;
    sign_d  = sign_q;
    neg_d   = neg_q;
    if (is_esc) begin
      state_d = S_IDLE;
      op_d    = OP_ADD;
      a_d     = '0;
      b_d     = '0;
      r_d     = '0;
      sh_d    = '0;
      na_d    = '0;
      nb_d    = '0;
      cc_d    = '0;
      bcd_d   = '0;
      disp_d  = '0;
      sign_d  = 1'b0;
      neg_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_RESULT: begin
          if (is_dig) begin
            state_d = S_OPA;
            a_d     = dig_w;
            na_d    = 3'd1;
            disp_d  = disp_dig;
            neg_d   = 1'b0;
          end else if (is_op && state_q == S_RESULT) begin
            // chain: result magnitude becomes A, sign kept on show
            state_d = S_OPB;
            op_d    = op_k;
            a_d     = r_q;
            b_d     = '0;
            nb_d    = '0;
            disp_d  = '0;
          end
        end
        S_OPA: begin
          if (is_dig && na_q < DMAX) begin
            a_d    = a_q * TEN + dig_w;
            na_d   = na_q + 3'd1;
            disp_d = {disp_q[DB-5:0], dig};
          end else if (is_op) begin
            state_d = S_OPB;
            op_d    = op_k;
            b_d     = '0;
            nb_d    = '0;
            disp_d  = '0;
          end
        end
        S_OPB: begin
          if (is_dig && nb_q < DMAX) begin
            b_d    = b_q * TEN + dig_w;
            nb_d   = nb_q + 3'd1;
            disp_d = {disp_q[DB-5:0], dig};
          end else if (is_op) begin
            op_d = op_k;
          end else if (is_ent) begin
            state_d = S_CONV;
            r_d     = res_v;
            sh_d    = res_v;
            sign_d  = (op_q == OP_SUB) && lt_v;
            neg_d   = 1'b0;
            bcd_d   = '0;
            cc_d    = '0;
          end
        end
        S_CONV: begin
          // rotate so the spilled BCD bit lands in the spent binary slot
          sh_d  = {sh_q[W-2:0], bcd_adj[DB-1]};
          bcd_d = bcd_step;
          cc_d  = cc_q + 1'b1;
          if (cc_q == CLAST) begin
            state_d = S_RESULT;
            disp_d  = bcd_step;
            neg_d   = sign_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_CONV);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      sh_q    <= '0;
      na_q    <= '0;
      nb_q    <= '0;
      cc_q    <= '0;
      bcd_q   <= '0;
      disp_q  <= '0;
      sign_q  <= 1'b0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      sh_q    <= sh_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
      cc_q    <= cc_d;
      bcd_q   <= bcd_d;
      disp_q  <= disp_d;
      sign_q  <= sign_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
    end
  end

  assign disp  = disp_q;
  assign neg   = neg_q;
  assign busy  = busy_q;
  assign state = state_q;

endmodule

// File: tb/tb_kb_calc_ctrl.sv
// Directed bench for kb_calc_ctrl, DIGITS=2.
// Define KBCALC_MUL_EN to check the multiply build.
module tb_kb_calc_ctrl;

  localparam logic [8:0] K0 = 9'h045;
  localparam logic [8:0] K1 = 9'h016;
  localparam logic [8:0] K2 = 9'h01E;
  localparam logic [8:0] K3 = 9'h026;
  localparam logic [8:0] K4 = 9'h025;
  localparam logic [8:0] K5 = 9'h02E;
  localparam logic [8:0] K7 = 9'h03D;
  localparam logic [8:0] K9 = 9'h046;
  localparam logic [8:0] KADD = 9'h079;
  localparam logic [8:0] KSUB = 9'h07B;
  localparam logic [8:0] KMUL = 9'h07C;
  localparam logic [8:0] KENT = 9'h05A;
  localparam logic [8:0] KESC = 9'h076;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] disp;
  logic        neg;
  logic        busy;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  kb_calc_if kbi ();

  kb_calc_ctrl #(.DIGITS(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .kb    (kbi),
    .disp  (disp),
    .neg   (neg),
    .busy  (busy),
    .state (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [8:0] code);
    @(negedge clk);
    kbi.key_code  = code;
    kbi.key_valid = 1'b1;
    @(negedge clk);
    kbi.key_valid = 1'b0;
    kbi.key_code  = 9'h000;
  endtask

  task automatic keys(input logic [8:0] a, input logic [8:0] b,
                      input logic [8:0] c);
    press(a);
    press(b);
    press(c);
  endtask

  // Enter already pressed: count CONV cycles, then check the result.
  task automatic conv_check(input string tag,
                            input logic [15:0] exp_disp,
                            input logic exp_neg);
    int n;
    int nobusy;
    n = 0;
    nobusy = 0;
    while (state == 3'd3 && n < 50) begin
      if (busy !== 1'b1 || neg !== 1'b0) nobusy++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_cycles"}, n, 14);
    chk({tag, "_busy"}, nobusy, 0);
    chk({tag, "_state"}, state, 3'd4);
    chk({tag, "_busy_off"}, busy, 1'b0);
    chk({tag, "_disp"}, disp, exp_disp);
    chk({tag, "_neg"}, neg, exp_neg);
  endtask

  initial begin
    kbi.key_code  = 9'h000;
    kbi.key_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", state, 3'd0);
    chk("rst_disp", disp, 16'h0000);
    chk("rst_neg", neg, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;

    press(KADD);
    chk("idle_op_ign", state, 3'd0);
    press(KENT);
    chk("idle_ent_ign", state, 3'd0);

    press(K1);
    chk("first_dig", disp, 16'h0001);
    chk("opa_state", state, 3'd1);
    keys(K2, KADD, K3);
    chk("opb_state", state, 3'd2);
    press(K4);
    chk("opb_disp", disp, 16'h0034);
    press(KENT);
    chk("conv_enter", state, 3'd3);
    chk("conv_hold", disp, 16'h0034);
    conv_check("add", 16'h0046, 1'b0);
    press(KENT);
    chk("res_ent_ign", state, 3'd4);

    press(KESC);
    chk("esc_state", state, 3'd0);
    chk("esc_disp", disp, 16'h0000);
    keys(K0, K5, KSUB);
    keys(K9, K0, KENT);
    conv_check("sub", 16'h0085, 1'b1);
    press(KADD);
    chk("chain_state", state, 3'd2);
    chk("chain_neg", neg, 1'b1);
    chk("chain_disp", disp, 16'h0000);
    keys(K1, K0, KENT);
    conv_check("chain", 16'h0095, 1'b0);

    press(KESC);
    keys(K9, K9, KMUL);
`ifdef KBCALC_MUL_EN
    keys(K9, K9, KENT);
    conv_check("mul", 16'h9801, 1'b0);
`else
    chk("mul_ign_state", state, 3'd1);
    keys(K9, K9, KENT);
    chk("mul_ign_st2", state, 3'd1);
    chk("mul_ign_disp", disp, 16'h0099);
    press(KESC);
    keys(K9, K9, KADD);
    keys(K9, K9, KENT);
    conv_check("add99", 16'h0198, 1'b0);
`endif

    press(KESC);
    keys(K1, K2, K3);
    chk("trunc_disp", disp, 16'h0012);
    press(9'h01C);
    chk("unk_disp", disp, 16'h0012);
    chk("unk_state", state, 3'd1);
    press(9'h116);
    chk("ext_disp", disp, 16'h0012);

    press(KESC);
    keys(K1, KSUB, K2);
    press(KENT);
    conv_check("neg1", 16'h0001, 1'b1);
    press(K7);
    chk("restart_st", state, 3'd1);
    chk("restart_disp", disp, 16'h0007);
    chk("restart_neg", neg, 1'b0);

    press(KESC);
    keys(K1, KADD, K2);
    press(KENT);
    repeat (4) @(negedge clk);
    chk("mid_conv", state, 3'd3);
    press(K5);
    chk("conv_dig_ign", state, 3'd3);
    press(KESC);
    chk("conv_esc_st", state, 3'd0);
    chk("conv_esc_disp", disp, 16'h0000);
    chk("conv_esc_busy", busy, 1'b0);

    keys(K4, KADD, K5);
    chk("pre_rst_disp", disp, 16'h0005);
    @(negedge clk);
    rst = 1'b0;
    kbi.key_code  = K1;
    kbi.key_valid = 1'b1;
    @(negedge clk);
    kbi.key_valid = 1'b0;
    chk("mid_rst_state", state, 3'd0);
    chk("mid_rst_disp", disp, 16'h0000);
    chk("mid_rst_neg", neg, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
